uart_cmd_frame: RTL and testbench
=================================

Name: uart_cmd_frame

Overview:
Parametrised command/response framer between an 8-bit byte UART and the command processor. Assembles CMD_BYTES received bytes, MSB first, into one command word and raises a ready flag. Serialises a RESP_BYTES-wide response back through the UART transmitter. Adds inter-byte timeout resync, overrun detection and multi-byte responses; a new frame can be collected while the previous command is still pending.

Parameters:
CMD_BYTES, 2, bytes per command frame (>=1)
RESP_BYTES, 1, bytes per response (>=1)
TIMEOUT_CYC, 50000, clk cycles allowed between bytes of a partial frame; 0 disables timeout

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_rdy  input  1  UART has a received byte
rx_data  input  8  UART received byte
clr_rx_rdy  output  1  consume current UART byte
trmt  output  1  start UART transmit of tx_data
tx_data  output  8  byte to transmit
tx_done  input  1  UART finished current byte
cmd  output  8*CMD_BYTES  assembled command, first byte in MSBs
cmd_rdy  output  1  cmd valid, held until cleared
clr_cmd_rdy  input  1  consumer has taken cmd
overrun  output  1  sticky: completed frame dropped
timeout_err  output  1  1-cycle pulse: partial frame discarded
resp  input  8*RESP_BYTES  response word, MSB byte sent first
send_resp  input  1  request to send resp
resp_busy  output  1  response transmission in progress
resp_sent  output  1  1-cycle pulse after last response byte

Behaviour:
- Reset (rst high at clk edge): cmd=0, cmd_rdy=0, overrun=0, timeout_err=0, trmt=0, tx_data=0, resp_busy=0, resp_sent=0, byte count=0, timeout counter=0, TX FSM=TX_IDLE. Clock and reset are fixed: one clk, rst synchronous and active-high.
- RX byte accept:
  - clr_rx_rdy = rx_rdy, combinational. Every byte is consumed in the same cycle; the RX path never stalls.
  - On accept: shift register <= {shift[8*CMD_BYTES-9:0], rx_data}.
  - On accept, byte count increments, or wraps to 0 if the byte was the last of the frame.
- Frame complete (accept with count==CMD_BYTES-1):
  - If cmd_rdy==0, or clr_cmd_rdy is high in the same cycle: next cycle cmd <= completed frame and cmd_rdy=1. Latency is 1 cycle from the final rx_rdy.
  - Otherwise the frame is discarded, cmd is unchanged, and overrun <= 1.
  - overrun is cleared only by rst.
- cmd_rdy and cmd:
  - cmd_rdy: clr_cmd_rdy clears it; set-by-completion wins over clear in the same cycle.
  - cmd holds stable whenever cmd_rdy==1 and no new completion is loaded.
- Timeout (TIMEOUT_CYC>0):
  - Counter resets to 0 on every accept and whenever count==0.
  - Otherwise it increments each cycle while count!=0.
  - When the counter reaches TIMEOUT_CYC-1 with no accept that cycle: count <= 0, partial data is discarded, timeout_err pulses 1 cycle.
  - A byte arriving in that same cycle wins: it is accepted and no timeout occurs.
  - cmd and cmd_rdy are unaffected by a timeout.
- TX FSM: TX_IDLE -> TX_LOAD -> TX_WAIT -> (TX_LOAD | TX_IDLE).
  - TX_IDLE: when send_resp=1, latch resp into the TX shift register, idx <= 0, go to TX_LOAD.
  - TX_LOAD: trmt=1 for exactly one cycle. tx_data = byte idx (MSB byte first), registered, held stable until the next TX_LOAD. Go to TX_WAIT.
  - TX_WAIT: on tx_done, if idx==RESP_BYTES-1 go to TX_IDLE with resp_sent pulsing that cycle. Otherwise idx++ and go to TX_LOAD.
  - First trmt occurs 1 cycle after send_resp is accepted.
  - resp_busy = (state != TX_IDLE).
  - send_resp while resp_busy is ignored. resp changes after latch do not affect the bytes in flight.
  - tx_done seen in TX_IDLE or TX_LOAD is ignored.
- RX and TX paths are fully independent; simultaneous activity is legal.
- rst mid-frame or mid-response aborts immediately to reset values. No trmt or resp_sent is produced afterwards.

Test Plan:
- CMD_BYTES=2: bytes 0xA5 then 0x3C, 10 cycles apart -> clr_rx_rdy high in each rx_rdy cycle; cmd_rdy=1 the cycle after the second byte; cmd=16'hA53C.
- CMD_BYTES=3: send 0x12,0x34,0x56; assert clr_cmd_rdy; send 0x78,0x9A,0xBC -> cmd=24'h123456 then 24'h789ABC; overrun=0.
- Overrun, CMD_BYTES=2: complete 0x1111, do not clear, complete 0x2222 -> cmd stays 16'h1111, overrun=1 and stays 1 after clr_cmd_rdy. Repeat with clr_cmd_rdy coinciding with the last byte -> cmd=16'h2222, cmd_rdy=1, overrun=0.
- Timeout, TIMEOUT_CYC=20: send 0xFF, wait 25 cycles -> timeout_err pulse at cycle 20 after the byte; then 0xDE,0xAD -> cmd=16'hDEAD. Byte arriving exactly on the timeout cycle -> no timeout_err.
- RESP_BYTES=2: send_resp with resp=16'hBEEF; tx_done returned 8 cycles after each trmt -> trmt pulses with tx_data=0xBE then 0xEF; resp_sent pulses with the second tx_done; resp_busy high throughout; a second send_resp mid-transfer is ignored.
- Reset mid-operation: rst during byte 2 of 3 and during a response -> all outputs return to reset values; the next full frame assembles correctly from byte 0.

Source files
------------

// File: rtl/uart_cmd_frame.sv
// uart_cmd_frame
//   Framer between an 8-bit byte UART and the command processor.
//   RX side: collects CMD_BYTES bytes (first byte ends up in the MSBs of cmd),
//   raises cmd_rdy, flags dropped frames (overrun) and discards stale partial
//   frames after TIMEOUT_CYC idle cycles (timeout_err pulse).
//   TX side: serialises a RESP_BYTES-wide response, MSB byte first, through
//   the UART transmitter handshake (trmt / tx_done).
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   rx_rdy, rx_data     UART received byte and its valid flag
//   clr_rx_rdy          consumes the UART byte (always same cycle as rx_rdy)
//   cmd, cmd_rdy        assembled command word and its held valid flag
//   clr_cmd_rdy         consumer has taken cmd
//   overrun             sticky: a completed frame was dropped
//   timeout_err         1-cycle pulse: a partial frame was discarded
//   resp, send_resp     response word and its send request
//   trmt, tx_data       UART transmit strobe and byte
//   tx_done             UART finished the current byte
//   resp_busy           response transmission in progress
//   resp_sent           1-cycle pulse with the last byte's tx_done
module uart_cmd_frame #(
  parameter int CMD_BYTES   = 2,
  parameter int RESP_BYTES  = 1,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_rdy,
  input  logic [7:0]              rx_data,
  output logic                    clr_rx_rdy,
  output logic                    trmt,
  output logic [7:0]              tx_data,
  input  logic                    tx_done,
  output logic [8*CMD_BYTES-1:0]  cmd,
  output logic                    cmd_rdy,
  input  logic                    clr_cmd_rdy,
  output logic                    overrun,
  output logic                    timeout_err,
  input  logic [8*RESP_BYTES-1:0] resp,
  input  logic                    send_resp,
  output logic                    resp_busy,
  output logic                    resp_sent
);

  localparam int CMD_W  = 8 * CMD_BYTES;
  localparam int RESP_W = 8 * RESP_BYTES;
  localparam int CNT_W  = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int IDX_W  = (RESP_BYTES > 1) ? $clog2(RESP_BYTES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT_CYC > 0) ? TMR_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BYTES - 1);

  // ---------------------------------------------------------------- RX path
  logic [CNT_W-1:0] byte_cnt;
  logic [TMR_W-1:0] timer;
  logic [CMD_W-1:0] frame;
  logic             frame_done;
  logic             timeout_hit;

  // The UART byte is always taken immediately, so the RX path never stalls.
  assign clr_rx_rdy = rx_rdy;

  // A frame completes on the accept of its last byte. A timeout only fires on
  // a partial frame and loses to a byte arriving in the same cycle.
  always_comb begin
    frame_done  = rx_rdy && (byte_cnt == CNT_LAST);
    timeout_hit = (TIMEOUT_CYC > 0) && !rx_rdy && (byte_cnt != '0) && (timer == TMR_LAST);
  end

  // frame is the would-be command if the current byte were the last one:
  // previously collected bytes on top, the incoming byte at the bottom.
  generate
    if (CMD_BYTES == 1) begin : g_single
      assign frame = rx_data;
    end else begin : g_multi
      logic [CMD_W-9:0] part_q;
      assign frame = {part_q, rx_data};

      // Holds the bytes of the frame collected so far.
      always_ff @(posedge clk) begin
        if (rst) begin
          part_q <= '0;
        end else if (rx_rdy) begin
          part_q <= frame[CMD_W-9:0];
        end else if (timeout_hit) begin
          part_q <= '0;
        end
      end
    end
  endgenerate

  // Byte position within the frame and the inter-byte idle timer. The timer
  // only runs while a partial frame is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt    <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (rx_rdy) begin
        byte_cnt <= frame_done ? '0 : byte_cnt + 1'b1;
      end else if (timeout_hit) begin
        byte_cnt <= '0;
      end
      if (rx_rdy || (byte_cnt == '0) || timeout_hit) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Command hand-off. A completed frame is loaded when the slot is free or is
  // being freed this very cycle; otherwise it is dropped and overrun latches.
  // Loading a new frame takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
    end else if (frame_done && (!cmd_rdy || clr_cmd_rdy)) begin
      cmd     <= frame;
      cmd_rdy <= 1'b1;
    end else begin
      if (frame_done) begin
        overrun <= 1'b1;
      end
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- TX path
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT
  } tx_state_t;

  tx_state_t         state;
  tx_state_t         state_next;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic [RESP_W-1:0] tx_shift;
  logic [7:0]        next_byte;
  logic              latch_resp;
  logic              advance;

  assign resp_busy = (state != TX_IDLE);

  // Next-state logic. trmt is asserted for the single TX_LOAD cycle of each
  // byte; resp_sent coincides with the tx_done of the final byte.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    latch_resp = 1'b0;
    advance    = 1'b0;
    trmt       = 1'b0;
    resp_sent  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (send_resp) begin
          latch_resp = 1'b1;
          idx_next   = '0;
          state_next = TX_LOAD;
        end
      end
      TX_LOAD: begin
        trmt       = 1'b1;
        state_next = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) begin
          if (idx == IDX_LAST) begin
            resp_sent  = 1'b1;
            state_next = TX_IDLE;
          end else begin
            idx_next   = idx + 1'b1;
            advance    = 1'b1;
            state_next = TX_LOAD;
          end
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  // Selects byte idx_next of the latched response, counting from the MSB end.
  always_comb begin
    next_byte = '0;
    for (int i = 0; i < RESP_BYTES; i++) begin
      if (idx_next == IDX_W'(RESP_BYTES - 1 - i)) begin
        next_byte = tx_shift[8*i +: 8];
      end
    end
  end

  // State register plus the latched response. tx_data is updated only when
  // entering TX_LOAD, so it stays stable while the UART shifts the byte out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_IDLE;
      idx      <= '0;
      tx_shift <= '0;
      tx_data  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (latch_resp) begin
        tx_shift <= resp;
        tx_data  <= resp[RESP_W-1 -: 8];
      end else if (advance) begin
        tx_data <= next_byte;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_frame.sv
// tb_uart_cmd_frame
//   Self-checking bench for uart_cmd_frame.
//   dut   : CMD_BYTES=2, RESP_BYTES=2, TIMEOUT_CYC=20, shadowed every cycle by
//           a queue-based reference model (table, timeout, response and
//           random phases).
//   dut_3 : CMD_BYTES=3, RESP_BYTES=1, TIMEOUT_CYC=0, checked by hand-written
//           sequences (3-byte frames, reset mid-frame / mid-response).
module tb_uart_cmd_frame;

  localparam int TO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic        rst, rx_rdy, clr_rx_rdy, trmt, tx_done;
  logic [7:0]  rx_data, tx_data;
  logic [15:0] cmd, resp;
  logic        cmd_rdy, clr_cmd_rdy, overrun, timeout_err;
  logic        send_resp, resp_busy, resp_sent;

  // 3-byte instance signals
  logic        rst_3, rx_rdy_3, clr_rx_rdy_3, trmt_3, tx_done_3;
  logic [7:0]  rx_data_3, tx_data_3, resp_3;
  logic [23:0] cmd_3;
  logic        cmd_rdy_3, clr_cmd_rdy_3, overrun_3, timeout_err_3;
  logic        send_resp_3, resp_busy_3, resp_sent_3;

  uart_cmd_frame #(.CMD_BYTES(2), .RESP_BYTES(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .overrun(overrun), .timeout_err(timeout_err),
    .resp(resp), .send_resp(send_resp), .resp_busy(resp_busy), .resp_sent(resp_sent)
  );

  uart_cmd_frame #(.CMD_BYTES(3), .RESP_BYTES(1), .TIMEOUT_CYC(0)) dut_3 (
    .clk(clk), .rst(rst_3), .rx_rdy(rx_rdy_3), .rx_data(rx_data_3), .clr_rx_rdy(clr_rx_rdy_3),
    .trmt(trmt_3), .tx_data(tx_data_3), .tx_done(tx_done_3), .cmd(cmd_3), .cmd_rdy(cmd_rdy_3),
    .clr_cmd_rdy(clr_cmd_rdy_3), .overrun(overrun_3), .timeout_err(timeout_err_3),
    .resp(resp_3), .send_resp(send_resp_3), .resp_busy(resp_busy_3), .resp_sent(resp_sent_3)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ------------------------------------------------------ reference model
  // RX: bytes of the partial frame in a queue, timeout from cycle distance.
  // TX: queue of bytes still to be sent plus a "strobe this cycle" flag.
  logic [7:0]  m_part[$];
  int          m_cyc;
  int          m_last;
  logic [15:0] m_cmd;
  bit          m_cmd_rdy, m_ovr, m_terr;
  logic [7:0]  m_txq[$];
  bit          m_trmt_due;
  logic [7:0]  m_cur;

  bit seen_resp_sent;
  bit seen_resp_sent_3;
  bit seen_clr_3;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_part.delete();
    m_txq.delete();
    m_cmd      = '0;
    m_cmd_rdy  = 1'b0;
    m_ovr      = 1'b0;
    m_terr     = 1'b0;
    m_trmt_due = 1'b0;
    m_cur      = '0;
    m_last     = 0;
  endtask

  // Advances the model across one rising edge using the inputs being held.
  task automatic model_edge();
    bit loaded;
    m_cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    m_terr = 1'b0;
    loaded = 1'b0;
    if (rx_rdy) begin
      m_part.push_back(rx_data);
      m_last = m_cyc;
      if (m_part.size() == 2) begin
        if (!m_cmd_rdy || clr_cmd_rdy) begin
          m_cmd     = {m_part[0], m_part[1]};
          m_cmd_rdy = 1'b1;
          loaded    = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        m_part.delete();
      end
    end else if (m_part.size() > 0 && (m_cyc - m_last) == TO) begin
      m_part.delete();
      m_terr = 1'b1;
    end
    if (!loaded && clr_cmd_rdy) m_cmd_rdy = 1'b0;

    if (m_txq.size() == 0) begin
      if (send_resp) begin
        m_txq.push_back(resp[15:8]);
        m_txq.push_back(resp[7:0]);
        m_cur      = m_txq[0];
        m_trmt_due = 1'b1;
      end
    end else if (m_trmt_due) begin
      m_trmt_due = 1'b0;
    end else if (tx_done) begin
      void'(m_txq.pop_front());
      if (m_txq.size() > 0) begin
        m_cur      = m_txq[0];
        m_trmt_due = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    bit busy;
    busy = (m_txq.size() > 0);
    check_output("cmd", cmd, m_cmd);
    check_output("cmd_rdy", cmd_rdy, m_cmd_rdy);
    check_output("overrun", overrun, m_ovr);
    check_output("timeout_err", timeout_err, m_terr);
    check_output("tx_data", tx_data, m_cur);
    check_output("trmt", trmt, m_trmt_due);
    check_output("resp_busy", resp_busy, busy);
    check_output("resp_sent", resp_sent, busy && !m_trmt_due && tx_done && (m_txq.size() == 1));
    check_output("clr_rx_rdy", clr_rx_rdy, rx_rdy);
  endtask

  // One cycle on the main instance: drive after the falling edge, compare,
  // let the rising edge happen, update the model, return at the next falling edge.
  task automatic apply_stimulus(input bit r, input bit rdy, input logic [7:0] d, input bit clr,
                                input bit snd, input logic [15:0] rs, input bit done);
    rst         = r;
    rx_rdy      = rdy;
    rx_data     = d;
    clr_cmd_rdy = clr;
    send_resp   = snd;
    resp        = rs;
    tx_done     = done;
    #1;
    compare_model();
    seen_resp_sent = resp_sent;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // One cycle on the 3-byte instance.
  task automatic step3(input bit r, input bit rdy, input logic [7:0] d, input bit clr,
                       input bit snd, input logic [7:0] rs, input bit done);
    rst_3         = r;
    rx_rdy_3      = rdy;
    rx_data_3     = d;
    clr_cmd_rdy_3 = clr;
    send_resp_3   = snd;
    resp_3        = rs;
    tx_done_3     = done;
    #1;
    seen_resp_sent_3 = resp_sent_3;
    seen_clr_3       = (clr_rx_rdy_3 == rx_rdy_3);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ------------------------------------------------------ directed RX table
  typedef struct {
    bit          r;
    bit          rdy;
    logic [7:0]  data;
    bit          clr;
    int          gap;
    bit          exp_rdy;
    logic [15:0] exp_cmd;
    bit          exp_ovr;
  } rx_vec_t;

  rx_vec_t tbl[$];

  task automatic add_vec(input bit r, input bit rdy, input logic [7:0] data, input bit clr,
                         input int gap, input bit exp_rdy, input logic [15:0] exp_cmd,
                         input bit exp_ovr);
    rx_vec_t v;
    v.r = r; v.rdy = rdy; v.data = data; v.clr = clr; v.gap = gap;
    v.exp_rdy = exp_rdy; v.exp_cmd = exp_cmd; v.exp_ovr = exp_ovr;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] sent[$];
    int         since;
    int         done_cnt;
    int         rs_cnt;
    int         rs_at_done;
    int         extra;
    int         terr_cnt;
    bit         finished;
    bit         done_now;

    // initial reset of both instances, no comparisons yet
    {rst, rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done} = '0;
    {rx_rdy_3, rx_data_3, clr_cmd_rdy_3, send_resp_3, resp_3, tx_done_3} = '0;
    rst   = 1'b1;
    rst_3 = 1'b1;
    model_reset();
    m_cyc = 0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    rst_3 = 1'b0;
    @(negedge clk);

    // ---- 3-byte instance (main instance sits idle and unchanged meanwhile)
    step3(0, 1, 8'h12, 0, 0, 8'h00, 0);
    check_output("d3 clr_rx_rdy follows rx_rdy", seen_clr_3, 1);
    step3(0, 1, 8'h34, 0, 0, 8'h00, 0);
    check_output("d3 cmd_rdy mid-frame", cmd_rdy_3, 0);
    step3(0, 1, 8'h56, 0, 0, 8'h00, 0);
    check_output("d3 cmd 123456", cmd_3, 24'h123456);
    check_output("d3 cmd_rdy set", cmd_rdy_3, 1);
    step3(0, 0, 8'h00, 1, 0, 8'h00, 0);
    check_output("d3 cmd_rdy cleared", cmd_rdy_3, 0);
    step3(0, 1, 8'h78, 0, 0, 8'h00, 0);
    step3(0, 1, 8'h9A, 0, 0, 8'h00, 0);
    step3(0, 1, 8'hBC, 0, 0, 8'h00, 0);
    check_output("d3 cmd 789ABC", cmd_3, 24'h789ABC);
    check_output("d3 overrun", overrun_3, 0);
    step3(0, 0, 8'h00, 1, 0, 8'h00, 0);

    // reset during byte 2 of 3
    step3(0, 1, 8'h11, 0, 0, 8'h00, 0);
    step3(1, 1, 8'h22, 0, 0, 8'h00, 0);
    check_output("d3 cmd after rst", cmd_3, 0);
    check_output("d3 cmd_rdy after rst", cmd_rdy_3, 0);

    // reset during a response
    step3(0, 0, 8'h00, 0, 1, 8'h5A, 0);
    check_output("d3 trmt", trmt_3, 1);
    check_output("d3 tx_data", tx_data_3, 8'h5A);
    check_output("d3 resp_busy", resp_busy_3, 1);
    step3(0, 0, 8'h00, 0, 0, 8'h00, 0);
    step3(1, 0, 8'h00, 0, 0, 8'h00, 1);
    check_output("d3 resp_busy after rst", resp_busy_3, 0);
    check_output("d3 tx_data after rst", tx_data_3, 0);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      if (trmt_3) extra++;
      step3(0, 0, 8'h00, 0, 0, 8'h00, 1);
      if (seen_resp_sent_3) extra++;
    end
    check_output("d3 no trmt/resp_sent after rst", extra, 0);

    // full frame from byte 0 after the aborted one
    step3(0, 1, 8'hAA, 0, 0, 8'h00, 0);
    step3(0, 1, 8'hBB, 0, 0, 8'h00, 0);
    step3(0, 1, 8'hCC, 0, 0, 8'h00, 0);
    check_output("d3 cmd AABBCC", cmd_3, 24'hAABBCC);
    check_output("d3 cmd_rdy AABBCC", cmd_rdy_3, 1);
    step3(0, 0, 8'h00, 1, 0, 8'h00, 0);

    // timeout disabled: widely spaced bytes still form one frame
    terr_cnt = 0;
    step3(0, 1, 8'h01, 0, 0, 8'h00, 0);
    for (int k = 0; k < 40; k++) begin
      step3(0, 0, 8'h00, 0, 0, 8'h00, 0);
      if (timeout_err_3) terr_cnt++;
    end
    step3(0, 1, 8'h02, 0, 0, 8'h00, 0);
    step3(0, 1, 8'h03, 0, 0, 8'h00, 0);
    check_output("d3 no timeout when disabled", terr_cnt, 0);
    check_output("d3 cmd 010203", cmd_3, 24'h010203);

    // ---- main instance: RX table
    //       rst rdy data   clr gap rdy  cmd       ovr
    add_vec(1, 0, 8'h00, 0, 0, 0, 16'h0000, 0);
    add_vec(0, 1, 8'hA5, 0, 9, 0, 16'h0000, 0);
    add_vec(0, 1, 8'h3C, 0, 0, 1, 16'hA53C, 0);
    add_vec(0, 0, 8'h00, 1, 0, 0, 16'hA53C, 0);
    add_vec(0, 1, 8'h11, 0, 0, 0, 16'hA53C, 0);
    add_vec(0, 1, 8'h11, 0, 0, 1, 16'h1111, 0);
    add_vec(0, 1, 8'h22, 0, 0, 1, 16'h1111, 0);
    add_vec(0, 1, 8'h22, 0, 0, 1, 16'h1111, 1);
    add_vec(0, 0, 8'h00, 1, 0, 0, 16'h1111, 1);
    add_vec(1, 0, 8'h00, 0, 0, 0, 16'h0000, 0);
    add_vec(0, 1, 8'h11, 0, 0, 0, 16'h0000, 0);
    add_vec(0, 1, 8'h11, 0, 0, 1, 16'h1111, 0);
    add_vec(0, 1, 8'h22, 0, 0, 1, 16'h1111, 0);
    add_vec(0, 1, 8'h22, 1, 0, 1, 16'h2222, 0);
    add_vec(0, 0, 8'h00, 1, 0, 0, 16'h2222, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_stimulus(tbl[i].r, tbl[i].rdy, tbl[i].data, tbl[i].clr, 0, 16'h0000, 0);
      check_output($sformatf("vec%0d cmd_rdy", i), cmd_rdy, tbl[i].exp_rdy);
      check_output($sformatf("vec%0d cmd", i), cmd, tbl[i].exp_cmd);
      check_output($sformatf("vec%0d overrun", i), overrun, tbl[i].exp_ovr);
      for (int g = 0; g < tbl[i].gap; g++) apply_stimulus(0, 0, 8'h00, 0, 0, 16'h0000, 0);
    end

    // ---- timeout: pulse exactly TO edges after the lone byte
    apply_stimulus(0, 1, 8'hFF, 0, 0, 16'h0000, 0);
    for (int k = 1; k <= 25; k++) begin
      apply_stimulus(0, 0, 8'h00, 0, 0, 16'h0000, 0);
      check_output($sformatf("timeout_err k=%0d", k), timeout_err, (k == TO));
    end
    apply_stimulus(0, 1, 8'hDE, 0, 0, 16'h0000, 0);
    apply_stimulus(0, 1, 8'hAD, 0, 0, 16'h0000, 0);
    check_output("cmd DEAD after timeout", cmd, 16'hDEAD);
    check_output("cmd_rdy DEAD", cmd_rdy, 1);
    apply_stimulus(0, 0, 8'h00, 1, 0, 16'h0000, 0);

    // byte arriving on the timeout cycle wins
    terr_cnt = 0;
    apply_stimulus(0, 1, 8'h01, 0, 0, 16'h0000, 0);
    for (int k = 1; k < TO; k++) begin
      apply_stimulus(0, 0, 8'h00, 0, 0, 16'h0000, 0);
      if (timeout_err) terr_cnt++;
    end
    apply_stimulus(0, 1, 8'h02, 0, 0, 16'h0000, 0);
    if (timeout_err) terr_cnt++;
    apply_stimulus(0, 0, 8'h00, 0, 0, 16'h0000, 0);
    if (timeout_err) terr_cnt++;
    check_output("no timeout on boundary byte", terr_cnt, 0);
    check_output("cmd 0102 boundary", cmd, 16'h0102);
    apply_stimulus(0, 0, 8'h00, 1, 0, 16'h0000, 0);

    // ---- two-byte response with UART returning tx_done 8 cycles after trmt
    since      = -1;
    done_cnt   = 0;
    rs_cnt     = 0;
    rs_at_done = -1;
    finished   = 1'b0;
    for (int c = 0; c < 60 && !finished; c++) begin
      if (trmt) begin
        sent.push_back(tx_data);
        since = 0;
      end
      if (c >= 1) check_output($sformatf("resp_busy c=%0d", c), resp_busy, 1);
      done_now = (since == 8);
      apply_stimulus(0, 0, 8'h00, 0, (c == 0) || (c == 12), (c == 0) ? 16'hBEEF : 16'h1234, done_now);
      if (done_now) done_cnt++;
      if (seen_resp_sent) begin
        rs_cnt++;
        rs_at_done = done_now ? done_cnt : -1;
      end
      if (since >= 0) since++;
      if (done_cnt == 2) finished = 1'b1;
    end
    check_output("response finished in budget", finished, 1);
    check_output("trmt count", sent.size(), 2);
    if (sent.size() >= 2) begin
      check_output("first byte", sent[0], 8'hBE);
      check_output("second byte", sent[1], 8'hEF);
    end
    check_output("resp_sent count", rs_cnt, 1);
    check_output("resp_sent on 2nd tx_done", rs_at_done, 2);
    check_output("resp_busy after response", resp_busy, 0);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      if (trmt) extra++;
      apply_stimulus(0, 0, 8'h00, 0, 0, 16'h0000, 1);
    end
    check_output("ignored send_resp produced no trmt", extra, 0);

    // ---- randomized traffic against the model, alternating dense/sparse RX
    for (int c = 0; c < 3000; c++) begin
      int p;
      p = ((c / 250) % 2 == 0) ? 35 : 4;
      apply_stimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < p), 8'($urandom),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 16'($urandom),
                     ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
